// File: rtl/enc_stream_encoder_if.sv
// Handshake bundle for the SECDED stream encoder: raw-word input side,
// codeword output side and the sent-word counter.
interface enc_stream_encoder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            codeword_width;
    logic [DATA_WIDTH-1:0] inject_mask;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] codeword;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_WIDTH-1:0]  words_sent;

    modport slave (
        input  data_in, codeword_width, inject_mask, in_valid, out_ready,
        output in_ready, codeword, out_valid, words_sent
    );

    modport master (
        output data_in, codeword_width, inject_mask, in_valid, out_ready,
        input  in_ready, codeword, out_valid, words_sent
    );
endinterface

// File: rtl/enc_stream_encoder.sv
// Two-stage SECDED Hamming encoder: S1 holds the raw word, S2 holds the
// registered codeword (data above parity, overall parity as the top parity bit).
module enc_stream_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    enc_stream_encoder_if.slave  bus
);

    // Valid/ready: a word moves across an interface on a rising edge where
    // valid and ready are both high; a held valid keeps its payload stable
    // until taken, and ready may depend combinationally on downstream ready.

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [1:0]            s1_mode_q,  s1_mode_d;
    logic [DATA_WIDTH-1:0] s1_mask_q,  s1_mask_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] codeword_q, codeword_d;
    logic [CNT_WIDTH-1:0]  words_sent_q, words_sent_d;
    logic                  s2_advance;
    logic                  s1_take;

    function automatic logic [31:0] data_mask(input logic [1:0] mode);
        case (mode)
            2'b00:   data_mask = 32'h0000_000F;
            2'b01:   data_mask = 32'h0000_07FF;
            default: data_mask = 32'h03FF_FFFF;
        endcase
    endfunction

    // Data bits occupy the non-power-of-two Hamming positions in ascending
    // order; parity bit i covers every data bit whose position has bit i set.
    function automatic logic [31:0] encode(input logic [31:0] d, input logic [1:0] mode);
        logic [4:0]  p;
        logic [4:0]  pos;
        logic [4:0]  j;
        logic [2:0]  np;
        logic [5:0]  lim;
        logic        ovr;
        np  = (mode == 2'b00) ? 3'd3 : (mode == 2'b01) ? 3'd4 : 3'd5;
        lim = 6'd1 << np;
        p   = '0;
        j   = '0;
        for (int q = 1; q < 32; q++) begin
            pos = 5'(q);
            if (({1'b0, pos} < lim) && ((pos & (pos - 5'd1)) != 5'd0)) begin
                for (int i = 0; i < 5; i++) begin
                    if (pos[i] && d[j]) p[i] = ~p[i];
                end
                j = j + 5'd1;
            end
        end
        ovr = ^{d, p};
        case (mode)
            2'b00:   encode = {24'd0, d[3:0], ovr, p[2:0]};
            2'b01:   encode = {16'd0, d[10:0], ovr, p[3:0]};
            default: encode = {d[25:0], ovr, p[4:0]};
        endcase
    endfunction

    assign s2_advance   = !s2_valid_q || bus.out_ready;
    assign s1_take      = !s1_valid_q || s2_advance;
    assign bus.in_ready = !rst && s1_take;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_mode_d    = s1_mode_q;
        s1_mask_d    = s1_mask_q;
        s2_valid_d   = s2_valid_q;
        codeword_d   = codeword_q;
        words_sent_d = words_sent_q;

        if (s1_take) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d = bus.data_in & data_mask(bus.codeword_width);
                s1_mode_d = bus.codeword_width;
                s1_mask_d = bus.inject_mask;
            end
        end

        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) codeword_d = encode(s1_data_q, s1_mode_q) ^ s1_mask_q;
        end

        if (s2_valid_q && bus.out_ready)
            words_sent_d = words_sent_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_mode_q    <= 2'b00;
            s1_mask_q    <= '0;
            s2_valid_q   <= 1'b0;
            codeword_q   <= '0;
            words_sent_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_mode_q    <= s1_mode_d;
            s1_mask_q    <= s1_mask_d;
            s2_valid_q   <= s2_valid_d;
            codeword_q   <= codeword_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.codeword   = codeword_q;
    assign bus.words_sent = words_sent_q;

endmodule
